// File: rtl/word_clipper_pkg.sv
// rtl/word_clipper_pkg.sv - shared constants for the word clipper detect stage
package word_clipper_pkg;

  localparam logic [1:0] ST_SILENCE  = 2'd0;
  localparam logic [1:0] ST_ONSET    = 2'd1;
  localparam logic [1:0] ST_WORD     = 2'd2;
  localparam logic [1:0] ST_HANGOVER = 2'd3;

  localparam int DEF_SAMPLE_W   = 16;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_WIN_LOG2   = 8;
  localparam int DEF_ON_THRESH  = 512000;
  localparam int DEF_OFF_THRESH = 256000;

  // A window sum of 2^win_log2 magnitudes of at most 2^(sample_w-1) always fits.
  function automatic int energy_w(input int sample_w, input int win_log2);
    return sample_w + win_log2;
  endfunction

endpackage

// File: rtl/word_energy_acc.sv
// rtl/word_energy_acc.sv - block-window magnitude accumulator with address capture
module word_energy_acc
  import word_clipper_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  localparam int ENERGY_W = energy_w(SAMPLE_W, WIN_LOG2)
) (
  input  logic                       iclk,
  input  logic                       irstn,
  input  logic                       isample_valid,
  input  logic signed [SAMPLE_W-1:0] isample,
  input  logic        [ADDR_W-1:0]   isample_addr,
  input  logic                       iflush,
  output logic                       owin_done,
  output logic        [ENERGY_W-1:0] oenergy,
  output logic        [ADDR_W-1:0]   ofirst_addr,
  output logic        [ADDR_W-1:0]   olast_addr
);

  logic [SAMPLE_W-1:0] raw;
  logic [SAMPLE_W-1:0] mag;
  logic [ENERGY_W-1:0] acc;
  logic [ENERGY_W-1:0] acc_sum;
  logic [WIN_LOG2-1:0] cnt;
  logic [ADDR_W-1:0]   first_addr;

  // Magnitude is unsigned so the most negative sample maps to 2^(SAMPLE_W-1).
  assign raw     = isample;
  assign mag     = raw[SAMPLE_W-1] ? (~raw + SAMPLE_W'(1)) : raw;
  assign acc_sum = acc + ENERGY_W'(mag);

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      acc         <= '0;
      cnt         <= '0;
      first_addr  <= '0;
      owin_done   <= 1'b0;
      oenergy     <= '0;
      ofirst_addr <= '0;
      olast_addr  <= '0;
    end else begin
      owin_done <= 1'b0;
      if (iflush) begin
        acc <= '0;
        cnt <= '0;
      end else if (isample_valid) begin
        cnt <= cnt + WIN_LOG2'(1);
        if (cnt == '0) first_addr <= isample_addr;
        if (&cnt) begin
          acc         <= '0;
          owin_done   <= 1'b1;
          oenergy     <= acc_sum;
          ofirst_addr <= first_addr;
          olast_addr  <= isample_addr;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: rtl/word_clipper_detect.sv
// rtl/word_clipper_detect.sv - energy hysteresis word boundary detector
module word_clipper_detect
  import word_clipper_pkg::*;
#(
  parameter int SAMPLE_W         = DEF_SAMPLE_W,
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int WIN_LOG2         = DEF_WIN_LOG2,
  parameter int MIN_ON_WINDOWS   = 3,
  parameter int HANG_WINDOWS     = 6,
  parameter int MAX_WORD_WINDOWS = 64,
  localparam int ENERGY_W = energy_w(SAMPLE_W, WIN_LOG2)
) (
  input  logic                       iclk,
  input  logic                       irstn,
  input  logic                       isample_valid,
  input  logic signed [SAMPLE_W-1:0] isample,
  input  logic        [ADDR_W-1:0]   isample_addr,
  input  logic                       iflush,
  input  logic        [ENERGY_W-1:0] ion_thresh,
  input  logic        [ENERGY_W-1:0] ioff_thresh,
  output logic                       ovalid,
  output logic        [ADDR_W-1:0]   ostart_addr,
  output logic        [ADDR_W-1:0]   oend_addr,
  output logic                       obusy
);

  localparam int OW = $clog2(MIN_ON_WINDOWS + 1);
  localparam int WW = $clog2(MAX_WORD_WINDOWS + 1);
  localparam int HW = $clog2(HANG_WINDOWS + 1);

  logic                win_done;
  logic [ENERGY_W-1:0] win_energy;
  logic [ADDR_W-1:0]   win_first;
  logic [ADDR_W-1:0]   win_last;

  logic [1:0]        state, state_n;
  logic [OW-1:0]     on_cnt, on_n;
  logic [WW-1:0]     wcnt, w_n;
  logic [HW-1:0]     hcnt, h_n;
  logic [ADDR_W-1:0] cand_start, cand_n;
  logic [ADDR_W-1:0] last_loud, last_n;
  logic              emit;
  logic              loud, sustain;

  word_energy_acc #(
    .SAMPLE_W (SAMPLE_W),
    .ADDR_W   (ADDR_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_acc (
    .iclk          (iclk),
    .irstn         (irstn),
    .isample_valid (isample_valid),
    .isample       (isample),
    .isample_addr  (isample_addr),
    .iflush        (iflush),
    .owin_done     (win_done),
    .oenergy       (win_energy),
    .ofirst_addr   (win_first),
    .olast_addr    (win_last)
  );

  assign loud    = win_energy >= ion_thresh;
  assign sustain = win_energy >= ioff_thresh;
  assign obusy   = state != ST_SILENCE;

  always_comb begin
    state_n = state;
    on_n    = on_cnt;
    w_n     = wcnt;
    h_n     = hcnt;
    cand_n  = cand_start;
    last_n  = last_loud;
    emit    = 1'b0;
    if (win_done) begin
      case (state)
        ST_SILENCE: begin
          if (loud) begin
            cand_n = win_first;
            w_n    = WW'(1);
            on_n   = OW'(1);
            if (MIN_ON_WINDOWS == 1) begin
              state_n = ST_WORD;
              last_n  = win_last;
            end else begin
              state_n = ST_ONSET;
            end
          end
        end
        ST_ONSET: begin
          if (loud) begin
            on_n = on_cnt + OW'(1);
            w_n  = wcnt + WW'(1);
            if (on_n == OW'(MIN_ON_WINDOWS)) begin
              state_n = ST_WORD;
              last_n  = win_last;
            end
          end else begin
            state_n = ST_SILENCE;
          end
        end
        default: begin
          w_n = wcnt + WW'(1);
          if (sustain) begin
            last_n  = win_last;
            h_n     = '0;
            state_n = ST_WORD;
          end else begin
            h_n     = hcnt + HW'(1);
            state_n = ST_HANGOVER;
          end
          // Length cap wins over hangover when both land on the same window.
          if (w_n == WW'(MAX_WORD_WINDOWS) || (!sustain && h_n == HW'(HANG_WINDOWS))) begin
            emit    = 1'b1;
            state_n = ST_SILENCE;
          end
        end
      endcase
    end
    // Flush acts on the post-window state, so a word already emitted here is not re-sent.
    if (iflush) begin
      if (state_n == ST_WORD || state_n == ST_HANGOVER) emit = 1'b1;
      state_n = ST_SILENCE;
    end
    if (state_n == ST_SILENCE) begin
      on_n = '0;
      w_n  = '0;
      h_n  = '0;
    end
  end

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      state       <= ST_SILENCE;
      on_cnt      <= '0;
      wcnt        <= '0;
      hcnt        <= '0;
      cand_start  <= '0;
      last_loud   <= '0;
      ovalid      <= 1'b0;
      ostart_addr <= '0;
      oend_addr   <= '0;
    end else begin
      state      <= state_n;
      on_cnt     <= on_n;
      wcnt       <= w_n;
      hcnt       <= h_n;
      cand_start <= cand_n;
      last_loud  <= last_n;
      ovalid     <= emit;
      if (emit) begin
        ostart_addr <= cand_n;
        oend_addr   <= last_n;
      end
    end
  end

endmodule

// File: tb/tb_word_clipper_detect.sv
// tb/tb_word_clipper_detect.sv - self-checking bench for word_clipper_detect
module tb_word_clipper_detect;

  localparam int WIN     = 4;
  localparam int MIN_ON  = 2;
  localparam int HANG    = 2;
  localparam int MAXW    = 8;
  localparam int ON_TH   = 2000;
  localparam int OFF_TH  = 1000;

  logic               iclk;
  logic               irstn;
  logic               isample_valid;
  logic signed [15:0] isample;
  logic [31:0]        isample_addr;
  logic               iflush;
  logic [17:0]        ion_thresh;
  logic [17:0]        ioff_thresh;
  logic               ovalid;
  logic [31:0]        ostart_addr;
  logic [31:0]        oend_addr;
  logic               obusy;

  word_clipper_detect #(
    .SAMPLE_W         (16),
    .ADDR_W           (32),
    .WIN_LOG2         (2),
    .MIN_ON_WINDOWS   (MIN_ON),
    .HANG_WINDOWS     (HANG),
    .MAX_WORD_WINDOWS (MAXW)
  ) dut (
    .iclk          (iclk),
    .irstn         (irstn),
    .isample_valid (isample_valid),
    .isample       (isample),
    .isample_addr  (isample_addr),
    .iflush        (iflush),
    .ion_thresh    (ion_thresh),
    .ioff_thresh   (ioff_thresh),
    .ovalid        (ovalid),
    .ostart_addr   (ostart_addr),
    .oend_addr     (oend_addr),
    .obusy         (obusy)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Behavioural model: windows as plain sums, word tracking as run lengths.
  int          cyc = 0;
  bit          model_ready = 0;
  int          n_in_win, win_sum;
  logic [31:0] win_first;
  bit          pend;
  int          pend_e;
  logic [31:0] pend_first, pend_last;
  bit          in_word;
  int          loud_run, quiet_run, wlen;
  logic [31:0] cand, last_loud;
  bit          exp_valid, exp_busy;
  logic [31:0] exp_start, exp_end;
  logic [31:0] trace_addr = 32'h137;
  int          mark_cyc = -100;

  function automatic void model_emit();
    exp_valid = 1'b1;
    exp_start = cand;
    exp_end   = last_loud;
    in_word   = 1'b0;
    loud_run  = 0;
    quiet_run = 0;
  endfunction

  function automatic void model_window(input int e, input logic [31:0] first, input logic [31:0] last);
    if (!in_word) begin
      if (e >= ON_TH) begin
        if (loud_run == 0) begin
          cand = first;
          wlen = 0;
        end
        loud_run++;
        wlen++;
        if (loud_run == MIN_ON) begin
          in_word   = 1'b1;
          last_loud = last;
          quiet_run = 0;
        end
      end else begin
        loud_run = 0;
      end
    end else begin
      wlen++;
      if (e >= OFF_TH) begin
        last_loud = last;
        quiet_run = 0;
      end else begin
        quiet_run++;
      end
      if (wlen == MAXW) model_emit();
      else if (quiet_run == HANG) model_emit();
    end
  endfunction

  initial begin
    forever begin
      @(posedge iclk);
      cyc++;
      exp_valid = 1'b0;
      if (!irstn) begin
        n_in_win = 0; win_sum = 0; pend = 0; in_word = 0;
        loud_run = 0; quiet_run = 0; wlen = 0;
        exp_start = '0; exp_end = '0;
      end else begin
        if (pend) model_window(pend_e, pend_first, pend_last);
        pend = 0;
        if (iflush) begin
          if (in_word) model_emit();
          in_word = 0; loud_run = 0; quiet_run = 0;
          n_in_win = 0; win_sum = 0;
        end else if (isample_valid) begin
          if (n_in_win == 0) win_first = isample_addr;
          win_sum += (isample < 0) ? -int'(isample) : int'(isample);
          n_in_win++;
          if (isample_addr == trace_addr) mark_cyc = cyc;
          if (n_in_win == WIN) begin
            pend = 1; pend_e = win_sum; pend_first = win_first; pend_last = isample_addr;
            n_in_win = 0; win_sum = 0;
          end
        end
      end
      exp_busy = in_word || (loud_run > 0);
      model_ready = 1'b1;
    end
  end

  // Compare process plus a log of observed words for the literal checks.
  int          words_n = 0;
  logic [31:0] w_start[$];
  logic [31:0] w_end[$];
  int          pulse_cyc = -1;
  int          busy_cycles = 0;

  initial begin
    forever begin
      @(negedge iclk);
      if (model_ready) begin
        check("ovalid", ovalid, exp_valid);
        check("obusy", obusy, exp_busy);
        check("ostart_addr", ostart_addr, exp_start);
        check("oend_addr", oend_addr, exp_end);
        if (ovalid) begin
          words_n++;
          w_start.push_back(ostart_addr);
          w_end.push_back(oend_addr);
          pulse_cyc = cyc;
        end
        if (obusy) busy_cycles++;
      end
    end
  end

  logic [31:0] cur_addr;

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge iclk);
      if (i == 1) check("rst_busy_next", obusy, 0);
      irstn         = 1'b0;
      isample_valid = 1'($urandom_range(0, 1));
      isample       = 16'($urandom);
      isample_addr  = $urandom;
      iflush        = 1'($urandom_range(0, 1));
    end
    @(negedge iclk);
    check("rst_ovalid", ovalid, 0);
    check("rst_obusy", obusy, 0);
    check("rst_ostart", ostart_addr, 0);
    check("rst_oend", oend_addr, 0);
    irstn = 1'b1; isample_valid = 1'b0; iflush = 1'b0; isample = '0; isample_addr = '0;
  endtask

  task automatic start_scenario();
    do_reset();
    words_n = 0; busy_cycles = 0; pulse_cyc = -1;
    w_start.delete(); w_end.delete();
    cur_addr = 32'h100;
  endtask

  task automatic send_sample(input int v, input bit fl);
    @(negedge iclk);
    isample_valid = 1'b1;
    isample       = 16'(v);
    isample_addr  = cur_addr;
    iflush        = fl;
    cur_addr      = cur_addr + 1;
  endtask

  task automatic send_win(input int v, input int n, input bit alt);
    for (int w = 0; w < n; w++)
      for (int s = 0; s < WIN; s++)
        send_sample((alt && s[0]) ? -v : v, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      isample_valid = 1'b0;
      iflush        = 1'b0;
    end
  endtask

  task automatic flush_only();
    @(negedge iclk);
    isample_valid = 1'b0;
    iflush        = 1'b1;
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] s, input logic [31:0] e);
    if (idx < w_start.size()) begin
      check({name, "_start"}, w_start[idx], s);
      check({name, "_end"}, w_end[idx], e);
    end else begin
      check({name, "_missing"}, idx, -1);
    end
  endtask

  initial begin
    irstn = 1'b0; isample_valid = 1'b0; isample = '0; isample_addr = '0; iflush = 1'b0;
    ion_thresh  = 18'(ON_TH);
    ioff_thresh = 18'(OFF_TH);

    // Basic word: hangover ends it, pulse one edge after sample 0x137.
    start_scenario();
    send_win(0, 8, 0); send_win(1000, 4, 1); send_win(0, 4, 0); idle(4);
    check("s1_count", words_n, 1);
    check_word("s1", 0, 32'h120, 32'h12F);
    check("s1_latency", pulse_cyc - mark_cyc, 1);

    // Single loud window never qualifies.
    start_scenario();
    send_win(0, 8, 0); send_win(1000, 1, 1); send_win(0, 3, 0); idle(4);
    check("s2_count", words_n, 0);
    check("s2_busy_cycles", busy_cycles, 4);

    // Sustain-level window keeps the word alive.
    start_scenario();
    send_win(0, 8, 0); send_win(1000, 2, 1); send_win(300, 1, 1);
    send_win(1000, 2, 1); send_win(0, 3, 0); idle(4);
    check("s3_count", words_n, 1);
    check_word("s3", 0, 32'h120, 32'h133);

    // Max-length forced end followed by a second word.
    start_scenario();
    send_win(0, 8, 0); send_win(1000, 10, 1); send_win(0, 3, 0); idle(4);
    check("s4_count", words_n, 2);
    check_word("s4a", 0, 32'h120, 32'h13F);
    check_word("s4b", 1, 32'h140, 32'h147);

    // Full-scale negative samples, flush mid-window.
    start_scenario();
    send_win(0, 8, 0); send_win(-32768, 3, 0);
    send_sample(-32768, 1'b0); send_sample(-32768, 1'b1);
    idle(2); send_win(0, 2, 0); idle(4);
    check("s5_count", words_n, 1);
    check_word("s5", 0, 32'h120, 32'h12B);

    // Flush landing on the window-evaluation cycle.
    start_scenario();
    send_win(0, 8, 0); send_win(1000, 4, 1); flush_only(); idle(4);
    check("s6_count", words_n, 1);
    check_word("s6", 0, 32'h120, 32'h12F);

    // Reset in the middle of a word drops it silently.
    start_scenario();
    send_win(0, 8, 0); send_win(1000, 3, 1);
    do_reset(); idle(4);
    check("s7_count", words_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
